// File: rtl/axrm_errmon_pkg.sv
// Shared types and constants for the approximate-multiplier error monitor.
package axrm_errmon_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

   localparam int OPND_W = 8;
   localparam int PROD_W = 16;

   // Smallest sum_ed width that cannot overflow over a full window of worst-case EDs.
   function automatic int min_acc_w(input int window_log2);
      return PROD_W + window_log2;
   endfunction

endpackage

// File: rtl/axrm_ed_calc.sv
// Combinational error distance |a*b - approx| and its non-zero flag.
module axrm_ed_calc
   import axrm_errmon_pkg::*;
(
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   input  logic [PROD_W-1:0] approx,
   output logic [PROD_W-1:0] ed,
   output logic              nz
);

   logic [PROD_W-1:0] exact;
   logic [PROD_W:0]   diff;
   logic [PROD_W:0]   mag;

   always_comb begin
      exact = PROD_W'(a) * PROD_W'(b);
      diff  = {1'b0, exact} - {1'b0, approx};
      // One extra bit keeps the sign, so the magnitude always fits PROD_W bits.
      mag   = diff[PROD_W] ? ((PROD_W+1)'(0) - diff) : diff;
      ed    = mag[PROD_W-1:0];
      nz    = (ed != '0);
   end

endmodule

// File: rtl/axrm_error_monitor.sv
// Windowed error-statistics collector for the 8x8 approximate multipliers.
// Define AXRM_ERRMON_SQERR_EN to add the sum_sq_ed (sum of ED^2) output.
module axrm_error_monitor
   import axrm_errmon_pkg::*;
#(
   parameter int WINDOW_LOG2 = 8,
   parameter int ACC_W       = 24
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [OPND_W-1:0]      in_a,
   input  logic [OPND_W-1:0]      in_b,
   input  logic [PROD_W-1:0]      in_approx,
   output logic                   busy,
   output logic                   stat_valid,
   output logic [ACC_W-1:0]       sum_ed,
   output logic [PROD_W-1:0]      max_ed,
   output logic [OPND_W-1:0]      max_a,
   output logic [OPND_W-1:0]      max_b,
   output logic [WINDOW_LOG2:0]   err_count
`ifdef AXRM_ERRMON_SQERR_EN
   ,
   output logic [31+WINDOW_LOG2:0] sum_sq_ed
`endif
);

   localparam int CNT_W = WINDOW_LOG2 + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << WINDOW_LOG2) - 1);

   if (WINDOW_LOG2 < 1 || WINDOW_LOG2 > 16) begin : g_bad_window
      $error("axrm_error_monitor: WINDOW_LOG2 must be in 1..16");
   end
   if (ACC_W < min_acc_w(WINDOW_LOG2)) begin : g_bad_acc
      $error("axrm_error_monitor: ACC_W too narrow for WINDOW_LOG2");
   end

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              fire, clr;
   logic [2:1]        vld_pipe;

   logic [OPND_W-1:0] s1_a, s1_b, s2_a, s2_b;
   logic [PROD_W-1:0] s1_ap, s2_ed, ed;
   logic              s2_nz, nz;

   assign in_ready   = (state == RUN);
   assign busy       = (state == RUN) || (state == DRAIN);
   assign stat_valid = (state == REPORT);
   assign fire       = in_valid && in_ready;
   assign clr        = (state == IDLE) && start;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (fire && cnt == CNT_LAST) state_nxt = DRAIN;
         DRAIN:   if (vld_pipe == 2'b00) state_nxt = REPORT;
         REPORT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (clr)       cnt <= '0;
         else if (fire) cnt <= cnt + CNT_W'(1);
      end
   end

   axrm_ed_calc u_ed (.a(s1_a), .b(s1_b), .approx(s1_ap), .ed(ed), .nz(nz));

   // S1 captures the sample, S2 holds ED; the accumulate below is S3.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_ap    <= '0;
         s2_a     <= '0;
         s2_b     <= '0;
         s2_ed    <= '0;
         s2_nz    <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[1], fire};
         if (fire) begin
            s1_a  <= in_a;
            s1_b  <= in_b;
            s1_ap <= in_approx;
         end
         if (vld_pipe[1]) begin
            s2_a  <= s1_a;
            s2_b  <= s1_b;
            s2_ed <= ed;
            s2_nz <= nz;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_ed    <= '0;
         max_ed    <= '0;
         max_a     <= '0;
         max_b     <= '0;
         err_count <= '0;
      end else if (clr) begin
         sum_ed    <= '0;
         max_ed    <= '0;
         max_a     <= '0;
         max_b     <= '0;
         err_count <= '0;
      end else if (vld_pipe[2]) begin
         sum_ed    <= sum_ed + ACC_W'(s2_ed);
         err_count <= err_count + CNT_W'(s2_nz);
         // Strict compare keeps the earliest sample on ties.
         if (s2_ed > max_ed) begin
            max_ed <= s2_ed;
            max_a  <= s2_a;
            max_b  <= s2_b;
         end
      end
   end

`ifdef AXRM_ERRMON_SQERR_EN
   logic [31:0] sq;
   assign sq = 32'(s2_ed) * 32'(s2_ed);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           sum_sq_ed <= '0;
      else if (clr)         sum_sq_ed <= '0;
      else if (vld_pipe[2]) sum_sq_ed <= sum_sq_ed + (32+WINDOW_LOG2)'(sq);
   end
`endif

endmodule

// File: tb/tb_axrm_error_monitor.sv
// Directed self-checking bench for axrm_error_monitor (WINDOW_LOG2=2, minimum ACC_W).
module tb_axrm_error_monitor;

   localparam int WL = 2;
   localparam int AW = 18;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_a = '0, in_b = '0;
   logic [15:0]   in_approx = '0;
   logic          in_ready, busy, stat_valid;
   logic [AW-1:0] sum_ed;
   logic [15:0]   max_ed;
   logic [7:0]    max_a, max_b;
   logic [WL:0]   err_count;
`ifdef AXRM_ERRMON_SQERR_EN
   logic [31+WL:0] sum_sq_ed;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_t = 0;

   axrm_error_monitor #(.WINDOW_LOG2(WL), .ACC_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .busy(busy), .stat_valid(stat_valid),
      .sum_ed(sum_ed), .max_ed(max_ed), .max_a(max_a), .max_b(max_b), .err_count(err_count)
`ifdef AXRM_ERRMON_SQERR_EN
      , .sum_sq_ed(sum_sq_ed)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   // One sample presented for exactly one rising edge; consecutive calls are back-to-back.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] ap);
      @(negedge clk);
      in_a = a; in_b = b; in_approx = ap; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      last_t = cyc;
   endtask

   task automatic wait_report(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (stat_valid) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({in_ready, busy, stat_valid} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {in_ready, busy, stat_valid}); end
      checks++; if (sum_ed !== '0) begin errors++; $display("FAIL reset_sum: got %0d want 0", sum_ed); end
      checks++; if (max_ed !== '0 || max_a !== '0 || max_b !== '0) begin errors++; $display("FAIL reset_max: got %0d/%0d/%0d want 0/0/0", max_ed, max_a, max_b); end
      checks++; if (err_count !== '0) begin errors++; $display("FAIL reset_err: got %0d want 0", err_count); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", in_ready); end
   endtask

   task automatic test_exact();
      bit ok;
      do_start();
      send(8'd10, 8'd20, 16'd200);
      send(8'd0, 8'd0, 16'd0);
      send(8'd255, 8'd255, 16'd65025);
      send(8'd7, 8'd9, 16'd63);
      wait_report(ok);
      checks++; if (!ok) begin errors++; $display("FAIL exact_report: got no stat_valid want pulse"); end
      checks++; if (sum_ed !== 18'd0) begin errors++; $display("FAIL exact_sum: got %0d want 0", sum_ed); end
      checks++; if (max_ed !== 16'd0 || max_a !== 8'd0 || max_b !== 8'd0) begin errors++; $display("FAIL exact_max: got %0d/%0d/%0d want 0/0/0", max_ed, max_a, max_b); end
      checks++; if (err_count !== 3'd0) begin errors++; $display("FAIL exact_err: got %0d want 0", err_count); end
   endtask

   task automatic test_known_errors();
      bit ok;
      do_start();
      send(8'd3, 8'd3, 16'd8);
      send(8'd255, 8'd255, 16'd65024);
      send(8'd16, 8'd16, 16'd260);
      send(8'd2, 8'd2, 16'd4);
      wait_report(ok);
      checks++; if (!ok) begin errors++; $display("FAIL known_report: got no stat_valid want pulse"); end
      checks++; if (sum_ed !== 18'd6) begin errors++; $display("FAIL known_sum: got %0d want 6", sum_ed); end
      checks++; if (max_ed !== 16'd4) begin errors++; $display("FAIL known_max: got %0d want 4", max_ed); end
      checks++; if (max_a !== 8'd16 || max_b !== 8'd16) begin errors++; $display("FAIL known_maxab: got %0d,%0d want 16,16", max_a, max_b); end
      checks++; if (err_count !== 3'd3) begin errors++; $display("FAIL known_err: got %0d want 3", err_count); end
`ifdef AXRM_ERRMON_SQERR_EN
      checks++; if (sum_sq_ed !== 34'd18) begin errors++; $display("FAIL known_sq: got %0d want 18", sum_sq_ed); end
`endif
   endtask

   task automatic test_sign_ties();
      bit ok;
      do_start();
      send(8'd1, 8'd1, 16'd17);
      send(8'd5, 8'd5, 16'd9);
      send(8'd0, 8'd0, 16'd0);
      send(8'd0, 8'd0, 16'd0);
      wait_report(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ties_report: got no stat_valid want pulse"); end
      checks++; if (sum_ed !== 18'd32) begin errors++; $display("FAIL ties_sum: got %0d want 32", sum_ed); end
      checks++; if (max_ed !== 16'd16) begin errors++; $display("FAIL ties_max: got %0d want 16", max_ed); end
      checks++; if (max_a !== 8'd1 || max_b !== 8'd1) begin errors++; $display("FAIL ties_maxab: got %0d,%0d want 1,1", max_a, max_b); end
      checks++; if (err_count !== 3'd2) begin errors++; $display("FAIL ties_err: got %0d want 2", err_count); end
`ifdef AXRM_ERRMON_SQERR_EN
      checks++; if (sum_sq_ed !== 34'd512) begin errors++; $display("FAIL ties_sq: got %0d want 512", sum_sq_ed); end
`endif
   endtask

   // Entered at the REPORT cycle; start is raised in the very cycle the FSM lands in IDLE.
   task automatic test_back_to_back();
      bit ok;
      @(negedge clk);
      checks++; if (stat_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got sv=%b busy=%b want 0/0", stat_valid, busy); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1 || sum_ed !== 18'd0) begin errors++; $display("FAIL b2b_start: got busy=%b sum=%0d want 1/0", busy, sum_ed); end
      send(8'd3, 8'd3, 16'd8);
      send(8'd16, 8'd16, 16'd260);
      send(8'd0, 8'd0, 16'd0);
      send(8'd0, 8'd0, 16'd0);
      wait_report(ok);
      checks++; if (!ok || sum_ed !== 18'd5) begin errors++; $display("FAIL b2b_sum: got ok=%b sum=%0d want 1/5", ok, sum_ed); end
`ifdef AXRM_ERRMON_SQERR_EN
      checks++; if (sum_sq_ed !== 34'd17) begin errors++; $display("FAIL sqerr_sum: got %0d want 17", sum_sq_ed); end
`endif
   endtask

   task automatic test_handshake();
      logic [7:0]  ta [4] = '{8'd4, 8'd9, 8'd0, 8'd200};
      logic [7:0]  tb [4] = '{8'd4, 8'd9, 8'd5, 8'd3};
      logic [15:0] tp [4] = '{16'd20, 16'd80, 16'd3, 16'd600};
      do_start();
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if (i == 2) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hs_run_ready: got %b want 1", in_ready); end
         end
         send(ta[i], tb[i], tp[i]);
      end
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         checks++; if (stat_valid !== (k == 3)) begin errors++; $display("FAIL hs_stat_t%0d: got %b want %b", k, stat_valid, (k == 3)); end
         checks++; if (busy !== (k < 3)) begin errors++; $display("FAIL hs_busy_t%0d: got %b want %b", k, busy, (k < 3)); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_t%0d: got %b want 0", k, in_ready); end
      end
      checks++; if (sum_ed !== 18'd8 || err_count !== 3'd3) begin errors++; $display("FAIL hs_result: got sum=%0d err=%0d want 8/3", sum_ed, err_count); end
      checks++; if (max_ed !== 16'd4 || max_a !== 8'd4 || max_b !== 8'd4) begin errors++; $display("FAIL hs_max: got %0d/%0d/%0d want 4/4/4", max_ed, max_a, max_b); end
      @(negedge clk);
      in_a = 8'd1; in_b = 8'd1; in_approx = 16'd999; in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      checks++; if (sum_ed !== 18'd8 || max_ed !== 16'd4 || err_count !== 3'd3) begin errors++; $display("FAIL hs_hold: got sum=%0d max=%0d err=%0d want 8/4/3", sum_ed, max_ed, err_count); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int seen;
      do_start();
      send(8'd3, 8'd3, 16'd8);
      send(8'd16, 8'd16, 16'd260);
      repeat (3) @(negedge clk);
      checks++; if (sum_ed !== 18'd5) begin errors++; $display("FAIL mid_partial: got %0d want 5", sum_ed); end
      rst_n = 1'b0;
      #1;
      checks++; if (sum_ed !== '0 || max_ed !== '0 || err_count !== '0 || busy !== 1'b0) begin errors++; $display("FAIL mid_clear: got sum=%0d max=%0d err=%0d busy=%b want 0", sum_ed, max_ed, err_count, busy); end
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (stat_valid || busy) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_report: got %0d active cycles want 0", seen); end
      do_start();
      send(8'd12, 8'd12, 16'd144);
      send(8'd1, 8'd200, 16'd200);
      send(8'd128, 8'd2, 16'd256);
      send(8'd0, 8'd77, 16'd0);
      wait_report(ok);
      checks++; if (!ok || sum_ed !== 18'd0 || err_count !== 3'd0) begin errors++; $display("FAIL mid_restart: got ok=%b sum=%0d err=%0d want 1/0/0", ok, sum_ed, err_count); end
   endtask

   initial begin
      test_reset();
      test_exact();
      test_known_errors();
      test_sign_ties();
      test_back_to_back();
      test_handshake();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
